// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Total bits on the wire for one frame, start bit included.
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 32'sd1 + data_bits + ((parity != PARITY_NONE) ? 32'sd1 : 32'sd0) + stop_bits;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Two-flop synchroniser for the raw RX pin plus a two-deep history so the
// current and two previous synchronised samples can be majority-voted.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic rx_s_o,
  output logic maj_o
);

  logic [1:0] sync_q;
  logic [1:0] hist_q;

  // Synchroniser and sample history, idle-high out of reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
      hist_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      hist_q <= {hist_q[0], sync_q[1]};
    end
  end

  assign rx_s_o = sync_q[1];
  assign maj_o  = majority3(hist_q[1], hist_q[0], sync_q[1]);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: framing FSM, bit counter, shift register and
// held output registers on top of the synchronised, majority-voted line.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_rx_uart,
  output logic                 o_rx_dv,
  output logic [DATA_BITS-1:0] o_rx_byte,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int IDX_W = 4;

  localparam logic [CNT_W-1:0] DECIDE_AT = CNT_W'(CLKS_PER_BIT / 2 + 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic             HAS_PARITY = (PARITY != PARITY_NONE);
  localparam logic             ODD_PARITY = (PARITY == PARITY_ODD);

  if ((CLKS_PER_BIT < 8) || (CLKS_PER_BIT > 65535)) begin : g_bad_clks_per_bit
    $error("uart_rx_cfg: CLKS_PER_BIT must be in 8..65535");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
    $error("uart_rx_cfg: DATA_BITS must be in 5..9");
  end
  if ((PARITY != PARITY_NONE) && (PARITY != PARITY_ODD) && (PARITY != PARITY_EVEN)) begin : g_bad_parity
    $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end

  logic rx_s;
  logic maj;

  rx_state_e            state_q,   state_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic [IDX_W-1:0]     idx_q,     idx_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;

  logic                 rx_dv_q,   rx_dv_d;
  logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
  logic                 par_out_q, par_out_d;
  logic                 frm_out_q, frm_out_d;
  logic                 busy_q,    busy_d;

  logic decide_s;
  logic done_s;

  uart_rx_sampler u_sampler (
    .clk_i  (i_clock),
    .rst_i  (i_reset),
    .rx_i   (i_rx_uart),
    .rx_s_o (rx_s),
    .maj_o  (maj)
  );

  // Every bit decision falls on the same counter value; the counter wraps per bit.
  assign decide_s = (cnt_q == DECIDE_AT);
  assign done_s   = (state_q == ST_STOP) && decide_s && (idx_q == LAST_STOP);

  // State register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) state_d = ST_START;
        else       state_d = ST_IDLE;
      end
      ST_START: begin
        if (decide_s) state_d = maj ? ST_IDLE : ST_DATA;
        else          state_d = ST_START;
      end
      ST_DATA: begin
        if (decide_s && (idx_q == LAST_DATA)) state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
        else                                  state_d = ST_DATA;
      end
      ST_PARITY: begin
        if (decide_s) state_d = ST_STOP;
        else          state_d = ST_PARITY;
      end
      ST_STOP: begin
        // Leave on the last decision, not at the end of the stop bit, so an
        // immediately following start bit is caught.
        if (done_s) state_d = ST_IDLE;
        else        state_d = ST_STOP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state: bit counter, bit index, shift register, error accumulators
  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;

    if (state_d == ST_IDLE) begin
      cnt_d = '0;
    end else if (cnt_q == LAST_CNT) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    case (state_q)
      ST_IDLE: begin
        idx_d     = '0;
        par_err_d = 1'b0;
        frm_err_d = 1'b0;
      end
      ST_START: begin
        idx_d = '0;
      end
      ST_DATA: begin
        if (decide_s) begin
          shift_d = {maj, shift_q[DATA_BITS-1:1]};
          idx_d   = (idx_q == LAST_DATA) ? '0 : (idx_q + IDX_ONE);
        end else begin
          idx_d = idx_q;
        end
      end
      ST_PARITY: begin
        if (decide_s) par_err_d = (^shift_q) ^ maj ^ ODD_PARITY;
        else          par_err_d = par_err_q;
      end
      ST_STOP: begin
        if (decide_s) begin
          idx_d     = idx_q + IDX_ONE;
          frm_err_d = frm_err_q | ~maj;
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        idx_d     = '0;
        par_err_d = 1'b0;
        frm_err_d = 1'b0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
    end
  end

  // Output logic: word and flags only move on the completion pulse
  always_comb begin
    rx_dv_d   = done_s;
    rx_byte_d = rx_byte_q;
    par_out_d = par_out_q;
    frm_out_d = frm_out_q;
    if (done_s) begin
      rx_byte_d = shift_q;
      par_out_d = par_err_q;
      frm_out_d = frm_err_q | ~maj;
    end else begin
      rx_byte_d = rx_byte_q;
    end
    busy_d = (state_d != ST_IDLE) | done_s;
  end

  // Output registers
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rx_dv_q   <= 1'b0;
      rx_byte_q <= '0;
      par_out_q <= 1'b0;
      frm_out_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_dv_q   <= rx_dv_d;
      rx_byte_q <= rx_byte_d;
      par_out_q <= par_out_d;
      frm_out_q <= frm_out_d;
      busy_q    <= busy_d;
    end
  end

  assign o_rx_dv      = rx_dv_q;
  assign o_rx_byte    = rx_byte_q;
  assign o_parity_err = par_out_q;
  assign o_frame_err  = frm_out_q;
  assign o_busy       = busy_q;

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver, the configurable successor to the team's fixed 8N1 receiver. It supports a configurable data width, optional odd/even parity and one or two stop bits. It hardens the input with a 2-flop synchroniser and 3-sample majority voting, and reports parity and framing errors alongside each received word. It sits between the board RX pin and any byte consumer (command decoder, RX FIFO) in the same clock domain.

## Interface

Parameters:
- CLKS_PER_BIT, 217, clock cycles per bit (25 MHz / 115200); legal range 8..65535.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- i_clock, in, 1, system clock.
- i_reset, in, 1, asynchronous active-high reset.
- i_rx_uart, in, 1, raw serial line; asynchronous; idle high.
- o_rx_dv, out, 1, one-cycle pulse when o_rx_byte and the error flags are valid.
- o_rx_byte, out, DATA_BITS, received word, LSB first on the wire; held until the next o_rx_dv.
- o_parity_err, out, 1, parity mismatch for the current word; 0 when PARITY=0; held with o_rx_byte.
- o_frame_err, out, 1, a stop bit was sampled low; held with o_rx_byte.
- o_busy, out, 1, high from start-bit detect until the frame completes or is aborted.

## Operation

**Input conditioning**
- i_rx_uart passes through 2 flops (reset value 1) to give rx_s.
- Each bit value is the majority of rx_s at counter values MID-1, MID and MID+1, where MID = CLKS_PER_BIT/2 (integer division).

**States:** IDLE, START, DATA, PARITY, STOP.
- IDLE: counter = 0 and bit index = 0. If rx_s = 0, go to START.
- START: the counter runs. At the decision point (count MID+1) a majority of 1 is a false start: go to IDLE with no o_rx_dv and no error. A majority of 0 means realign so that the next decision falls CLKS_PER_BIT cycles later, then go to DATA.
- DATA: store each bit at index 0..DATA_BITS-1. After the last bit go to PARITY if PARITY != 0, otherwise go to STOP.
- PARITY: compare the sampled bit with the XOR of the data. Odd mode expects data XOR parity = 1; even mode expects 0.
- STOP: decide STOP_BITS bits. Any low stop bit sets the frame error. After the final stop-bit decision, update the outputs, pulse o_rx_dv and go straight to IDLE. Do not wait for the end of the stop bit, so a start bit that follows immediately is caught.

**Error handling**
- A framing error still delivers the word, with o_frame_err = 1.
- If the line is held low (break), every stop bit fails and the word is delivered with o_frame_err = 1. The FSM then waits in IDLE. Because rx_s stays 0, it re-enters START, and the next frame again ends in a frame error. This is acceptable; there is no separate break detection.

**Counter**
- Width is $clog2(CLKS_PER_BIT+1).
- Compares use full-width equality; no wrap-around occurs inside a bit.

## Timing

- Reset values: o_rx_dv = 0, o_rx_byte = 0, o_parity_err = 0, o_frame_err = 0, o_busy = 0, state = IDLE, synchroniser flops = 1.
- Let T0 be the first cycle in which IDLE sees rx_s = 0. This is 2 to 3 cycles after the falling edge on the pin.
- The decision for frame bit k (start = 0) occurs at T0 + k*CLKS_PER_BIT + MID + 1.
- With N = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS, o_rx_dv is high exactly in cycle T0 + (N-1)*CLKS_PER_BIT + MID + 2.
- o_rx_byte and the error flags change only in the same cycle as o_rx_dv.
- o_busy is high from T0+1 until the o_rx_dv cycle, inclusive.
- Asserting i_reset at any point, including mid-frame, forces all reset values immediately. The partial frame is discarded with no o_rx_dv pulse.
- After reset is released, the first falling edge starts a fresh frame.

## Structure

- Package uart_pkg holds:
  - the state enum,
  - the parity mode constants PARITY_NONE/ODD/EVEN,
  - the function frame_bits(DATA_BITS, PARITY, STOP_BITS).
- Sub-module uart_rx_sampler contains the 2-flop synchroniser and the 3-tap majority register. Its outputs are rx_s and maj. It has no FSM.
- Top level contains the FSM, the counter, the shift register and the output registers.
- Elaboration-time assertions check the legal ranges of all parameters.

## Test plan

All cases use CLKS_PER_BIT = 16 unless noted.

1. 8N1, 0xA5 sent, then 0x3C sent back-to-back with a single stop bit -> two o_rx_dv pulses. Bytes are 0xA5 then 0x3C, both error flags 0. The first pulse lands at cycle T0 + 9*16 + 10.
2. Line driven low for 5 cycles, then high -> START aborts, no o_rx_dv, o_busy returns to 0, and the next valid frame is received correctly.
3. 7E2, 0x37 with parity bit 1 (correct) -> o_parity_err = 0. The same frame with parity bit 0 -> o_rx_byte = 0x37 and o_parity_err = 1.
4. 8N1, 0x81 with the stop bit driven low -> o_rx_dv pulses with o_rx_byte = 0x81 and o_frame_err = 1.
5. 8N1, 0x00 with a 1-cycle high glitch at the mid-sample point of bit 3 -> the majority vote gives o_rx_byte = 0x00, no error.
6. i_reset pulsed during data bit 4 of a 9O1 frame -> all outputs 0 and no o_rx_dv. A following frame of 0x1FF is received with o_parity_err = 0.
